// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Default parameter values and FSM state encoding shared by
//               the convolution frame engine and its MAC datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int c_DATA_W_DEF  = 16;
    localparam int c_FRAC_W_DEF  = 10;
    localparam int c_MAX_IMG_DEF = 32;
    localparam int c_MAX_K_DEF   = 5;
    localparam int c_ACC_W_DEF   = 40;

    localparam int c_ST_W = 3;

    localparam logic [c_ST_W-1:0] c_ST_IDLE   = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_LOAD   = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_MAC    = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_EMIT   = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_FINISH = 3'd4;

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac
// Description : Signed multiply-accumulate with fixed-point rescale, optional
//               ReLU and saturation. The result reflects the accumulator plus
//               the product presented this cycle, so the final tap of a window
//               can be registered by the caller on the same edge it lands.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int FRAC_W = c_FRAC_W_DEF,
    parameter int ACC_W  = c_ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_pix,
    input  logic [DATA_W-1:0] i_coef,
    input  logic              i_relu,
    output logic [DATA_W-1:0] o_result
);

    logic signed [2*DATA_W-1:0] w_pix_ext;
    logic signed [2*DATA_W-1:0] w_coef_ext;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_base;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    w_shift;
    logic signed [ACC_W-1:0]    w_relu;
    logic [ACC_W-DATA_W:0]      w_hi;
    logic signed [ACC_W-1:0]    r_acc;

    // Operands are widened first so the product is the exact 2*DATA_W result.
    assign w_pix_ext  = $signed({{DATA_W{i_pix[DATA_W-1]}}, i_pix});
    assign w_coef_ext = $signed({{DATA_W{i_coef[DATA_W-1]}}, i_coef});
    assign w_prod     = w_pix_ext * w_coef_ext;
    assign w_prod_ext = $signed({{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod});
    assign w_base     = i_clr ? '0 : r_acc;
    assign w_sum      = w_base + w_prod_ext;
    assign w_shift    = w_sum >>> FRAC_W;
    assign w_relu     = (i_relu && w_shift[ACC_W-1]) ? '0 : w_shift;
    assign w_hi       = w_relu[ACC_W-1:DATA_W-1];

    // Saturate: the value fits only if every bit above the output sign matches it.
    always_comb begin
        o_result = w_relu[DATA_W-1:0];
        if (!((&w_hi) || (~|w_hi))) begin
            o_result = w_relu[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // Accumulator restarts from zero on the first tap of each window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv_frame_engine
// Description : Frame-based 2-D convolution engine. Loads an NxN image, then
//               produces OxO cross-correlation results against a KxK kernel,
//               one tap per cycle, with a valid/ready result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_frame_engine
    import conv_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W_DEF,
    parameter int FRAC_W  = c_FRAC_W_DEF,
    parameter int MAX_IMG = c_MAX_IMG_DEF,
    parameter int MAX_K   = c_MAX_K_DEF,
    parameter int ACC_W   = c_ACC_W_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [$clog2(MAX_IMG+1)-1:0]     img_size,
    input  logic [$clog2(MAX_K+1)-1:0]       filter_size,
    input  logic                             stride2,
    input  logic                             relu_en,
    input  logic                             coef_we,
    input  logic [$clog2(MAX_K*MAX_K)-1:0]   coef_addr,
    input  logic [DATA_W-1:0]                coef_data,
    input  logic                             pix_valid,
    output logic                             pix_ready,
    input  logic [DATA_W-1:0]                pix_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int c_IMG_W      = $clog2(MAX_IMG+1);
    localparam int c_RW         = c_IMG_W + 1;
    localparam int c_K_W        = $clog2(MAX_K+1);
    localparam int c_CA_W       = $clog2(MAX_K*MAX_K);
    localparam int c_PIX_DEPTH  = MAX_IMG * MAX_IMG;
    localparam int c_PA_W       = $clog2(c_PIX_DEPTH);
    localparam int c_COEF_DEPTH = MAX_K * MAX_K;

    logic [c_ST_W-1:0]  r_state, w_state_nxt;
    logic [c_IMG_W-1:0] r_nmax, r_omax, r_row, r_col, r_orow, r_ocol;
    logic [c_K_W-1:0]   r_kmax, r_ki, r_kj;
    logic               r_s2, r_relu, r_err;
    logic [DATA_W-1:0]  r_out_data;
    logic [DATA_W-1:0]  r_img  [c_PIX_DEPTH];
    logic [DATA_W-1:0]  r_coef [c_COEF_DEPTH];

    logic               w_cfg_ok, w_accept, w_pix_hs, w_pix_last, w_k_last, w_o_last, w_coef_wr;
    logic [c_RW-1:0]    w_prow, w_pcol;
    logic [c_PA_W-1:0]  w_pix_raddr, w_pix_waddr;
    logic [c_CA_W-1:0]  w_coef_raddr;
    logic [DATA_W-1:0]  w_pix_rd, w_coef_rd, w_mac_result;

    assign w_cfg_ok   = (filter_size != '0) && (32'(filter_size) <= MAX_K)
                     && (img_size != '0) && (32'(img_size) <= MAX_IMG)
                     && (32'(filter_size) <= 32'(img_size));
    assign w_accept   = (r_state == c_ST_IDLE) && start && w_cfg_ok;
    assign w_pix_hs   = (r_state == c_ST_LOAD) && pix_valid;
    assign w_pix_last = w_pix_hs && (r_row == r_nmax) && (r_col == r_nmax);
    assign w_k_last   = (r_ki == r_kmax) && (r_kj == r_kmax);
    assign w_o_last   = (r_orow == r_omax) && (r_ocol == r_omax);
    assign w_coef_wr  = (r_state == c_ST_IDLE) && coef_we && (32'(coef_addr) < c_COEF_DEPTH);

    // Window tap coordinates; pixels are stored on a MAX_IMG-wide row pitch.
    assign w_prow       = (r_s2 ? {r_orow, 1'b0} : {1'b0, r_orow}) + c_RW'(r_ki);
    assign w_pcol       = (r_s2 ? {r_ocol, 1'b0} : {1'b0, r_ocol}) + c_RW'(r_kj);
    assign w_pix_raddr  = c_PA_W'(32'(w_prow) * MAX_IMG + 32'(w_pcol));
    assign w_pix_waddr  = c_PA_W'(32'(r_row) * MAX_IMG + 32'(r_col));
    assign w_coef_raddr = c_CA_W'(32'(r_ki) * (32'(r_kmax) + 1) + 32'(r_kj));
    assign w_pix_rd     = r_img[w_pix_raddr];
    assign w_coef_rd    = r_coef[w_coef_raddr];

    conv_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (reset),
        .i_en     (r_state == c_ST_MAC),
        .i_clr    ((r_ki == '0) && (r_kj == '0)),
        .i_pix    (w_pix_rd),
        .i_coef   (w_coef_rd),
        .i_relu   (r_relu),
        .o_result (w_mac_result)
    );

    // Image and kernel storage survive reset.
    always_ff @(posedge clk) begin
        if (!reset && w_pix_hs) begin
            r_img[w_pix_waddr] <= pix_data;
        end
        if (!reset && w_coef_wr) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept)   w_state_nxt = c_ST_LOAD;
            c_ST_LOAD:   if (w_pix_last) w_state_nxt = c_ST_MAC;
            c_ST_MAC:    if (w_k_last)   w_state_nxt = c_ST_EMIT;
            c_ST_EMIT:   if (out_ready)  w_state_nxt = w_o_last ? c_ST_FINISH : c_ST_MAC;
            c_ST_FINISH: w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Frame configuration, traversal counters, result register and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nmax     <= '0;
            r_omax     <= '0;
            r_kmax     <= '0;
            r_s2       <= 1'b0;
            r_relu     <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_orow     <= '0;
            r_ocol     <= '0;
            r_ki       <= '0;
            r_kj       <= '0;
            r_out_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= (r_state == c_ST_IDLE) && start && !w_cfg_ok;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_nmax <= img_size - c_IMG_W'(1);
                        r_kmax <= filter_size - c_K_W'(1);
                        r_omax <= (img_size - c_IMG_W'(filter_size)) >> stride2;
                        r_s2   <= stride2;
                        r_relu <= relu_en;
                        r_row  <= '0;
                        r_col  <= '0;
                        r_orow <= '0;
                        r_ocol <= '0;
                        r_ki   <= '0;
                        r_kj   <= '0;
                    end
                end
                c_ST_LOAD: begin
                    if (w_pix_hs) begin
                        if (r_col == r_nmax) begin
                            r_col <= '0;
                            r_row <= r_row + c_IMG_W'(1);
                        end else begin
                            r_col <= r_col + c_IMG_W'(1);
                        end
                    end
                end
                c_ST_MAC: begin
                    if (r_kj == r_kmax) begin
                        r_kj <= '0;
                        r_ki <= (r_ki == r_kmax) ? '0 : r_ki + c_K_W'(1);
                    end else begin
                        r_kj <= r_kj + c_K_W'(1);
                    end
                    if (w_k_last) begin
                        r_out_data <= w_mac_result;
                    end
                end
                c_ST_EMIT: begin
                    if (out_ready) begin
                        if (r_ocol == r_omax) begin
                            r_ocol <= '0;
                            r_orow <= r_orow + c_IMG_W'(1);
                        end else begin
                            r_ocol <= r_ocol + c_IMG_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_ready = (r_state == c_ST_LOAD);
    assign out_valid = (r_state == c_ST_EMIT);
    assign out_data  = r_out_data;
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = (r_state == c_ST_FINISH);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_frame_engine
// Description : Directed self-checking bench for conv_frame_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_frame_engine;

    logic        clk = 1'b0;
    logic        reset, start, stride2, relu_en, coef_we, pix_valid, out_ready;
    logic [5:0]  img_size;
    logic [2:0]  filter_size;
    logic [4:0]  coef_addr;
    logic [15:0] coef_data, pix_data;
    logic        pix_ready, out_valid, busy, done, err;
    logic [15:0] out_data;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    conv_frame_engine u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .img_size    (img_size),
        .filter_size (filter_size),
        .stride2     (stride2),
        .relu_en     (relu_en),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hand-derived results: 1.0*2.0*9 = 18.0 (0x4800); windows over the
    // -24.0 pixel give 16-48 = -32.0 (0x8000), or 0 with ReLU.
    function automatic logic [15:0] exp_val(input int mode, input int r, input int c);
        case (mode)
            0:       return (r == 0 && c >= 1 && c <= 3) ? 16'h8000 : 16'h4800;
            1:       return (r == 0 && c >= 1 && c <= 3) ? 16'h0000 : 16'h4800;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'h4800;
        endcase
    endfunction

    task automatic write_coefs(input logic [15:0] val);
        for (int i = 0; i < 9; i++) begin
            coef_we = 1'b1; coef_addr = 5'(i); coef_data = val;
            tick();
        end
        coef_we = 1'b0;
    endtask

    task automatic start_frame(input int n, input int k, input bit s2, input bit relu);
        img_size = 6'(n); filter_size = 3'(k); stride2 = s2; relu_en = relu;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic load(input int n, input logic [15:0] val, input int sp_idx,
                        input logic [15:0] sp_val, input bit try_coef);
        check("pix_ready_load", pix_ready, 1);
        if (try_coef) begin
            coef_we = 1'b1; coef_addr = 5'd4; coef_data = 16'h0000;
        end
        pix_valid = 1'b1;
        for (int i = 0; i < n * n; i++) begin
            pix_data = (i == sp_idx) ? sp_val : val;
            tick();
        end
        pix_valid = 1'b0;
        coef_we   = 1'b0;
        check("pix_ready_after_load", pix_ready, 0);
    endtask

    task automatic collect(input int o, input int mode, input bit lat_chk, input bit stall);
        for (int r = 0; r < o; r++) begin
            for (int c = 0; c < o; c++) begin
                int cnt;
                cnt = 0;
                while (out_valid !== 1'b1 && cnt < 200) begin
                    tick();
                    cnt++;
                end
                check("out_valid_wait", out_valid, 1);
                if (lat_chk && r == 0 && c == 0) check("first_latency", cnt, 9);
                check($sformatf("res_m%0d_(%0d,%0d)", mode, r, c), out_data, exp_val(mode, r, c));
                if (stall && r == 0 && c == 0) begin
                    for (int i = 0; i < 5; i++) begin
                        tick();
                        check("stall_valid", out_valid, 1);
                        check("stall_data", out_data, exp_val(mode, r, c));
                    end
                end
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
        end
        check("done_pulse", done, 1);
        tick();
        check("done_one_cycle", done, 0);
        check("busy_after_finish", busy, 0);
    endtask

    initial begin
        bit saw_done;
        reset = 1'b1; start = 1'b0; stride2 = 1'b0; relu_en = 1'b0; coef_we = 1'b0;
        pix_valid = 1'b0; out_ready = 1'b0; img_size = '0; filter_size = '0;
        coef_addr = '0; coef_data = '0; pix_data = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_pix_ready", pix_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // Rejected start: K larger than N.
        img_size = 6'd3; filter_size = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        tick();
        check("err_one_cycle", err, 0);
        check("err_busy_still", busy, 0);

        // Uniform frame with one strongly negative pixel, ReLU off then on.
        write_coefs(16'h0800);
        start_frame(6, 3, 1'b0, 1'b0);
        load(6, 16'h0400, 3, 16'hA000, 1'b0);
        collect(4, 0, 1'b1, 1'b0);

        start_frame(6, 3, 1'b0, 1'b1);
        load(6, 16'h0400, 3, 16'hA000, 1'b0);
        collect(4, 1, 1'b0, 1'b1);

        // Positive saturation, plus a bad start while busy that must be ignored.
        write_coefs(16'h7FFF);
        start_frame(6, 3, 1'b0, 1'b0);
        load(6, 16'h7FFF, -1, 16'h0000, 1'b0);
        img_size = 6'd3; filter_size = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy_no_err", err, 0);
        collect(4, 2, 1'b0, 1'b0);

        // Negative saturation.
        start_frame(6, 3, 1'b0, 1'b0);
        load(6, 16'h8000, -1, 16'h0000, 1'b0);
        collect(4, 3, 1'b0, 1'b0);

        // Stride 2; a coefficient write attempted while busy must not land.
        write_coefs(16'h0800);
        start_frame(6, 3, 1'b1, 1'b0);
        load(6, 16'h0400, -1, 16'h0000, 1'b1);
        collect(2, 4, 1'b0, 1'b0);

        // Reset in the middle of MAC abandons the frame silently.
        start_frame(6, 3, 1'b0, 1'b0);
        load(6, 16'h0400, -1, 16'h0000, 1'b0);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 0);

        // Stored coefficients persist across reset.
        start_frame(6, 3, 1'b1, 1'b0);
        load(6, 16'h0400, -1, 16'h0000, 1'b0);
        collect(2, 4, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
